hazard_controller: RTL and testbench

Pipeline sequencing controller for the five-stage RISC-V core, sitting beside the ID stage and driving the enable/flush controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves the three hazards forwarding cannot cover:
- load-use: single-cycle stall;
- taken branch/jump resolved in EX: two-stage flush;
- multi-cycle MUL/DIV occupying EX: counted freeze.

---
 rtl/hazard_pkg.sv | 39 +++
 rtl/md_stall_counter.sv | 28 ++
 rtl/hazard_controller.sv | 119 +++++++++++
 tb/tb_hazard_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// HAZARD_PERF_CNT_EN adds stall/flush perf counters to hazard_controller.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    RUN,
    MD_WAIT
  } hazard_state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CTRL_RUN    = hazard_ctrl_t'(6'b111_000);
  localparam hazard_ctrl_t CTRL_FREEZE = hazard_ctrl_t'(6'b000_001);
  localparam hazard_ctrl_t CTRL_BRANCH = hazard_ctrl_t'(6'b111_110);
  localparam hazard_ctrl_t CTRL_LDUSE  = hazard_ctrl_t'(6'b001_010);
  localparam hazard_ctrl_t CTRL_RESET  = hazard_ctrl_t'(6'b111_111);

  function automatic logic load_use(
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic                  rs1_used,
    input logic                  rs2_used,
    input logic [REG_ADDR_W-1:0] rd,
    input logic                  mem_read
  );
    return mem_read && (rd != '0) &&
           ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
  endfunction

endpackage

// File: rtl/md_stall_counter.sv
// EX-occupancy counter for multi-cycle MUL/DIV; flags the final cycle.
module md_stall_counter
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int W = $clog2(MD_LATENCY) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         advance,
  input  logic         clear,
  output logic         tc,
  output logic [W-1:0] md_cnt
);

  always_ff @(posedge clk) begin
    if (reset || clear)
      md_cnt <= '0;
    else if (load)
      md_cnt <= W'(1);
    else if (advance)
      md_cnt <= md_cnt + W'(1);
  end

  assign tc = (md_cnt == W'(MD_LATENCY - 1));

endmodule

// File: rtl/hazard_controller.sv
// Load-use stall, branch flush and MUL/DIV freeze sequencing.
// Optional perf counters when HAZARD_PERF_CNT_EN is defined.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_addr_ID,
  input  logic [REG_ADDR_W-1:0] rs2_addr_ID,
  input  logic                  rs1_used_ID,
  input  logic                  rs2_used_ID,
  input  logic [REG_ADDR_W-1:0] rd_addr_EX,
  input  logic                  mem_read_EX,
  input  logic                  muldiv_EX,
  input  logic                  branch_taken_EX,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  md_busy,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events,
`endif
  output logic                  md_done
);

  localparam int CW = $clog2(MD_LATENCY) + 1;

  hazard_state_t state;
  hazard_ctrl_t  ctrl;
  logic          tc;
  logic [CW-1:0] md_cnt;
  logic          ld_use;
  logic          in_run;
  logic          in_wait;
  logic          br_flush;

  assign in_run  = (state == RUN);
  assign in_wait = (state == MD_WAIT);
  assign ld_use  = load_use(rs1_addr_ID, rs2_addr_ID, rs1_used_ID,
                            rs2_used_ID, rd_addr_EX, mem_read_EX);

  md_stall_counter #(
    .MD_LATENCY(MD_LATENCY),
    .W(CW)
  ) u_cnt (
    .clk(clk),
    .reset(reset),
    .load(in_run && muldiv_EX),
    .advance(in_wait && !tc),
    .clear(in_wait && tc),
    .tc(tc),
    .md_cnt(md_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN:     if (muldiv_EX) state <= MD_WAIT;
        MD_WAIT: if (tc) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    ctrl     = CTRL_RUN;
    md_busy  = in_wait;
    md_done  = 1'b0;
    br_flush = 1'b0;
    if (reset) begin
      ctrl    = CTRL_RESET;
      md_busy = 1'b0;
    end else if (in_wait) begin
      if (tc) md_done = 1'b1;
      else    ctrl = CTRL_FREEZE;
    end else begin
      priority case (1'b1)
        muldiv_EX: ctrl = CTRL_FREEZE;
        branch_taken_EX: begin
          ctrl     = CTRL_BRANCH;
          br_flush = 1'b1;
        end
        ld_use:  ctrl = CTRL_LDUSE;
        default: ctrl = CTRL_RUN;
      endcase
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign if_id_en     = ctrl.if_id_en;
  assign id_ex_en     = ctrl.id_ex_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_flush = ctrl.ex_mem_flush;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!ctrl.pc_en) stall_cycles <= stall_cycles + 32'd1;
      if (br_flush)    flush_events <= flush_events + 32'd1;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{md_cnt, br_flush};
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller with MD_LATENCY=4.
module tb_hazard_controller;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_addr_ID, rs2_addr_ID, rd_addr_EX;
  logic       rs1_used_ID, rs2_used_ID;
  logic       mem_read_EX, muldiv_EX, branch_taken_EX;
  logic       pc_en, if_id_en, id_ex_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush;
  logic       md_busy, md_done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
  logic [31:0] m_stall, m_flush;
`endif

  int errors = 0;
  int checks = 0;
  int busy_left = 0;
  logic [7:0] obs, exp_v;

  always #5 clk = ~clk;

  hazard_controller #(.MD_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .rs1_addr_ID(rs1_addr_ID), .rs2_addr_ID(rs2_addr_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rd_addr_EX(rd_addr_EX), .mem_read_EX(mem_read_EX),
    .muldiv_EX(muldiv_EX), .branch_taken_EX(branch_taken_EX),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .md_busy(md_busy),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .md_done(md_done)
  );

  // {pc,ifid,idex,ifid_fl,idex_fl,exmem_fl,busy,done}
  function automatic logic [7:0] model_out();
    logic hit;
    hit = mem_read_EX && rd_addr_EX != 0 &&
          ((rs1_used_ID && rs1_addr_ID == rd_addr_EX) ||
           (rs2_used_ID && rs2_addr_ID == rd_addr_EX));
    if (reset)          return 8'b111_111_00;
    if (busy_left > 1)  return 8'b000_001_10;
    if (busy_left == 1) return 8'b111_000_11;
    if (muldiv_EX)      return 8'b000_001_00;
    if (branch_taken_EX) return 8'b111_110_00;
    if (hit)            return 8'b001_010_00;
    return 8'b111_000_00;
  endfunction

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, req);
    end
  endtask

  task automatic idle();
    reset = 0; mem_read_EX = 0; muldiv_EX = 0; branch_taken_EX = 0;
    rs1_used_ID = 0; rs2_used_ID = 0;
    rs1_addr_ID = 0; rs2_addr_ID = 0; rd_addr_EX = 0;
  endtask

  // Inputs are already applied; check mid-cycle, then advance the model.
  task automatic cycle();
    logic [7:0] m;
    @(negedge clk);
    obs = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush,
           ex_mem_flush, md_busy, md_done};
    m = model_out();
    exp_v = m;
    chk("model", obs, m);
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cycles !== m_stall || flush_events !== m_flush) begin
      errors++;
      $display("FAIL perf got=%0d/%0d want=%0d/%0d", stall_cycles,
               flush_events, m_stall, m_flush);
    end
`endif
    @(posedge clk);
`ifdef HAZARD_PERF_CNT_EN
    if (reset) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (!m[7]) m_stall++;
      if (m[4] && m[3] && busy_left == 0 && !muldiv_EX) m_flush++;
    end
`endif
    if (reset)              busy_left = 0;
    else if (busy_left > 0) busy_left--;
    else if (muldiv_EX)     busy_left = L - 1;
    #1;
  endtask

  task automatic set_ld_use(input logic [4:0] rd);
    mem_read_EX = 1; rd_addr_EX = rd;
    rs1_used_ID = 1; rs1_addr_ID = 5;
  endtask

  initial begin
    idle();
    reset = 1;
    cycle();
    chk("reset_out", obs, 8'b111_111_00);
    cycle();
    idle();
    cycle();
    chk("idle", obs, 8'b111_000_00);

    set_ld_use(5'd5);
    cycle();
    chk("ld_use", obs, 8'b001_010_00);
    idle();
    cycle();
    chk("ld_use_1cyc", obs, 8'b111_000_00);
    set_ld_use(5'd0);
    rs1_addr_ID = 0;
    cycle();
    chk("ld_use_x0", obs, 8'b111_000_00);

    idle();
    branch_taken_EX = 1;
    cycle();
    chk("branch", obs, 8'b111_110_00);
    idle();
    cycle();
    chk("branch_1cyc", obs, 8'b111_000_00);

    muldiv_EX = 1;
    cycle();
    chk("md_T0", obs, 8'b000_001_00);
    idle();
    set_ld_use(5'd5);
    branch_taken_EX = 1;
    cycle();
    chk("md_T1", obs, 8'b000_001_10);
    idle();
    cycle();
    chk("md_T2", obs, 8'b000_001_10);
    cycle();
    chk("md_T3", obs, 8'b111_000_11);
    cycle();
    chk("md_T4", obs, 8'b111_000_00);
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'd4 || flush_events !== 32'd1) begin
      errors++;
      $display("FAIL perf_lit got=%0d/%0d want=4/1",
               stall_cycles, flush_events);
    end
    @(posedge clk); #1;
`endif

    muldiv_EX = 1;
    cycle();
    idle();
    cycle();
    chk("rst_md_T1", obs, 8'b000_001_10);
    reset = 1;
    cycle();
    chk("rst_mid", obs, 8'b111_111_00);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rst_no_done", obs, 8'b111_000_00);
    end

    for (int i = 0; i < 3000; i++) begin
      idle();
      reset = ($urandom_range(0, 299) == 0);
      muldiv_EX = ($urandom_range(0, 19) == 0);
      branch_taken_EX = ($urandom_range(0, 7) == 0);
      mem_read_EX = ($urandom_range(0, 2) == 0);
      rd_addr_EX = 5'($urandom_range(0, 7));
      rs1_addr_ID = 5'($urandom_range(0, 7));
      rs2_addr_ID = 5'($urandom_range(0, 7));
      rs1_used_ID = 1'($urandom_range(0, 1));
      rs2_used_ID = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

`ifdef HAZARD_PERF_CNT_EN
  initial begin
    m_stall = 0; m_flush = 0;
  end
`endif

endmodule
